// File: rtl/pipeline_stage_elastic_if.sv
// Handshake bundle for pipeline_stage_elastic: upstream valid/ready/payload, downstream valid/ready/payload, status.
// slave is the pipeline's view; master is the view of whatever drives and consumes it.
interface pipeline_stage_elastic_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 3,
   parameter int CTRL_WIDTH = 10,
   parameter int DEPTH      = 1
);
   logic                             inValid;
   logic                             inReady;
   logic [CTRL_WIDTH-1:0]            inCtrl;
   logic [DATA_WIDTH*LANES-1:0]      inData;
   logic                             outValid;
   logic                             outReady;
   logic [CTRL_WIDTH-1:0]            outCtrl;
   logic [DATA_WIDTH*LANES-1:0]      outData;
   logic [$clog2(DEPTH+2)-1:0]       occupancy;
   logic [31:0]                      stallCount;

   modport slave (
      input  inValid, inCtrl, inData, outReady,
      output inReady, outValid, outCtrl, outData, occupancy, stallCount
   );

   modport master (
      output inValid, inCtrl, inData, outReady,
      input  inReady, outValid, outCtrl, outData, occupancy, stallCount
   );
endinterface

// File: rtl/pipeline_stage_elastic.sv
// Elastic DEPTH-stage register pipeline with 1-entry input skid (registered inReady), flush-to-bubble, DEPTH-cycle latency.
// Backpressure ripples stage to stage via outReady; optional stall counter under PIPE_STALL_CNT_EN.
module pipeline_stage_elastic #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 3,
   parameter int CTRL_WIDTH = 10,
   parameter int DEPTH      = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pipeline_stage_elastic_if.slave bus
);
   localparam int DW = DATA_WIDTH * LANES;
   localparam int OW = $clog2(DEPTH + 2);

   typedef struct packed {
      logic [CTRL_WIDTH-1:0] ctrl;
      logic [DW-1:0]         data;
   } entry_t;

   entry_t           stage_q [DEPTH];
   logic [DEPTH-1:0] stage_vld;
   entry_t           skid_q;
   logic             skid_vld;
   logic             in_rdy_q;

   entry_t           in_ent;
   entry_t           src [DEPTH];
   logic [DEPTH-1:0] src_vld;
   logic [DEPTH-1:0] load_en;
   logic [DEPTH-1:0] stage_vld_d;
   logic             skid_vld_d;
   logic             skid_load;
   logic             in_xfer;
   logic [OW-1:0]    occ;

   always_comb begin
      in_ent.ctrl = bus.inCtrl;
      in_ent.data = bus.inData;
      in_xfer     = bus.inValid && in_rdy_q && !flush;

      // A stage can load when it is empty or its own entry moves on this edge.
      load_en          = '0;
      load_en[DEPTH-1] = !stage_vld[DEPTH-1] || bus.outReady;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         load_en[i] = !stage_vld[i] || load_en[i+1];
      end

      src[0]     = skid_vld ? skid_q : in_ent;
      src_vld[0] = skid_vld || in_xfer;
      for (int i = 1; i < DEPTH; i++) begin
         src[i]     = stage_q[i-1];
         src_vld[i] = stage_vld[i-1];
      end

      for (int i = 0; i < DEPTH; i++) begin
         stage_vld_d[i] = flush ? 1'b0 : (load_en[i] ? src_vld[i] : stage_vld[i]);
      end

      skid_load = in_xfer && !skid_vld && !load_en[0];
      if (flush) begin
         skid_vld_d = 1'b0;
      end else if (skid_vld) begin
         skid_vld_d = !load_en[0];
      end else begin
         skid_vld_d = skid_load;
      end

      occ = OW'(skid_vld);
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ + OW'(stage_vld[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_vld <= '0;
         skid_vld  <= 1'b0;
         in_rdy_q  <= 1'b0;
         skid_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_vld <= stage_vld_d;
         skid_vld  <= skid_vld_d;
         in_rdy_q  <= !skid_vld_d;
         if (skid_load) begin
            skid_q <= in_ent;
         end
         // Payloads are frozen on flush; only the valid bits are killed.
         for (int i = 0; i < DEPTH; i++) begin
            if (!flush && load_en[i] && src_vld[i]) begin
               stage_q[i] <= src[i];
            end
         end
      end
   end

   assign bus.inReady   = in_rdy_q;
   assign bus.outValid  = stage_vld[DEPTH-1];
   assign bus.outCtrl   = stage_vld[DEPTH-1] ? stage_q[DEPTH-1].ctrl : '0;
   assign bus.outData   = stage_q[DEPTH-1].data;
   assign bus.occupancy = occ;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (stage_vld[DEPTH-1] && !bus.outReady && stall_q != 32'hFFFF_FFFF) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stallCount = stall_q;
`else
   assign bus.stallCount = '0;
`endif
endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic (DEPTH=2): queue-based timing model checked every cycle plus directed literal checks.
module tb_pipeline_stage_elastic;
   localparam int DEPTH = 2;
   localparam int DW    = 32;
   localparam int LANES = 3;
   localparam int CW    = 10;
   localparam int BW    = DW * LANES;
`ifdef PIPE_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic flush;

   pipeline_stage_elastic_if #(.DATA_WIDTH(DW), .LANES(LANES), .CTRL_WIDTH(CW), .DEPTH(DEPTH)) bus ();

   pipeline_stage_elastic #(.DATA_WIDTH(DW), .LANES(LANES), .CTRL_WIDTH(CW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: FIFO of held entries, each tagged with the edge after which it may sit at the output.
   typedef struct {
      logic [CW-1:0] ctrl;
      logic [BW-1:0] data;
      int            arr;
   } ment_t;
   typedef struct {
      logic [CW-1:0] ctrl;
      logic [BW-1:0] data;
   } obs_t;

   ment_t       mq[$];
   int          edge_n     = 0;
   bit          m_rst_q    = 1'b1;
   bit          model_live = 1'b0;
   logic [31:0] m_stall    = '0;

   obs_t dut_out[$];
   obs_t exp_q[$];
   bit   saw_d   = 1'b0;
   int   max_occ = 0;
   int   n0, cyc, sent;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_out_valid();
      return (mq.size() > 0) && (mq[0].arr <= edge_n);
   endfunction

   function automatic bit m_in_ready();
      return !m_rst_q && (mq.size() < DEPTH + 1);
   endfunction

   always @(posedge clk) begin : model
      bit ov, ir;
      ov = m_out_valid();
      ir = m_in_ready();
      edge_n++;
      model_live = 1'b1;
      if (!reset) begin
         mq.delete();
         m_rst_q = 1'b1;
         m_stall = '0;
      end else begin
         if (ov && !bus.outReady && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (ov && bus.outReady) begin
            void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].arr < edge_n) mq[0].arr = edge_n;
         end
         if (flush) mq.delete();
         if (bus.inValid && ir && !flush)
            mq.push_back('{ctrl: bus.inCtrl, data: bus.inData, arr: edge_n + DEPTH - 1});
         m_rst_q = 1'b0;
      end
   end

   always @(negedge clk) begin : compare
      bit ov;
      if (model_live) begin
         ov = m_out_valid();
         chk("inReady", bus.inReady, m_in_ready());
         chk("outValid", bus.outValid, ov);
         chk("outCtrl", bus.outCtrl, ov ? mq[0].ctrl : {CW{1'b0}});
         if (ov) chk("outData", bus.outData, mq[0].data);
         chk("occupancy", bus.occupancy, mq.size());
         chk("stallCount", bus.stallCount, STALL_EN ? m_stall : 32'd0);
         if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
         if (bus.outValid && bus.outReady) begin
            dut_out.push_back('{bus.outCtrl, bus.outData});
            if (bus.outData == BW'(13)) saw_d = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #2ms;
      n_fail++;
      $display("FAIL watchdog: run still active at %0t, required completion", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : stim
      reset        = 1'b0;
      flush        = 1'b0;
      bus.inValid  = 1'b1;
      bus.inCtrl   = '1;
      bus.inData   = '1;
      bus.outReady = 1'b1;

      // Reset held with a live input offer
      repeat (3) tick();
      chk("rst_inReady", bus.inReady, 0);
      chk("rst_outValid", bus.outValid, 0);
      chk("rst_outCtrl", bus.outCtrl, 0);
      chk("rst_outData", bus.outData, 0);
      chk("rst_occupancy", bus.occupancy, 0);
      chk("rst_stallCount", bus.stallCount, 0);
      bus.inValid = 1'b0;
      reset       = 1'b1;
      tick();
      chk("release_inReady", bus.inReady, 1);
      chk("release_occupancy", bus.occupancy, 0);

      // Latency: driven after edge t, visible after edge t+2
      n0          = dut_out.size();
      bus.inValid = 1'b1;
      bus.inCtrl  = 10'h3FF;
      bus.inData  = 96'h1;
      tick();
      bus.inValid = 1'b0;
      chk("lat_t1_outValid", bus.outValid, 0);
      tick();
      chk("lat_t2_outValid", bus.outValid, 1);
      chk("lat_t2_outCtrl", bus.outCtrl, 10'h3FF);
      chk("lat_t2_outData", bus.outData, 96'h1);
      tick();
      chk("lat_t3_outValid", bus.outValid, 0);
      chk("lat_transfers", dut_out.size() - n0, 1);

      // Fill to DEPTH+1 under backpressure, then drain
      bus.outReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.inValid = 1'b1;
         bus.inCtrl  = CW'(k + 1);
         bus.inData  = BW'(10 + k);
         tick();
      end
      bus.inValid = 1'b0;
      chk("full_occupancy", bus.occupancy, 3);
      chk("full_inReady", bus.inReady, 0);
      repeat (3) tick();
      chk("hold_occupancy", bus.occupancy, 3);
      chk("hold_head", bus.outData, 'hA);
      n0           = dut_out.size();
      bus.outReady = 1'b1;
      tick();
      chk("drain1_data", bus.outData, 'hB);
      tick();
      chk("drain2_data", bus.outData, 'hC);
      chk("drain2_valid", bus.outValid, 1);
      tick();
      chk("drain3_valid", bus.outValid, 0);
      chk("drain_count", dut_out.size() - n0, 3);
      for (int k = 0; k < 3 && n0 + k < dut_out.size(); k++)
         chk("drain_order", dut_out[n0+k].data, BW'(10 + k));

      // Flush a full pipe while offering 0xD
      n0           = dut_out.size();
      bus.outReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.inValid = 1'b1;
         bus.inCtrl  = CW'(k + 4);
         bus.inData  = BW'(17 + k);
         tick();
      end
      chk("preflush_occupancy", bus.occupancy, 3);
      flush       = 1'b1;
      bus.inValid = 1'b1;
      bus.inCtrl  = 10'h155;
      bus.inData  = 96'hD;
      tick();
      flush       = 1'b0;
      bus.inValid = 1'b0;
      chk("flush_occupancy", bus.occupancy, 0);
      chk("flush_outValid", bus.outValid, 0);
      chk("flush_outCtrl", bus.outCtrl, 0);
      chk("flush_inReady", bus.inReady, 1);
      chk("flush_payload_kept", bus.outData, 'h11);
      bus.outReady = 1'b1;
      repeat (5) tick();
      chk("flush_no_output", dut_out.size() - n0, 0);
      chk("flushed_entry_emitted", saw_d, 0);

      // Stall counter
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("stall_after_reset", bus.stallCount, 0);
      bus.outReady = 1'b0;
      bus.inValid  = 1'b1;
      bus.inCtrl   = 10'h2A;
      bus.inData   = 96'h77;
      tick();
      bus.inValid = 1'b0;
      tick();
      chk("stall_head_valid", bus.outValid, 1);
      chk("stall_start", bus.stallCount, 0);
      repeat (5) tick();
      chk("stall_5", bus.stallCount, STALL_EN ? 32'd5 : 32'd0);
      flush        = 1'b1;
      bus.outReady = 1'b1;
      tick();
      flush = 1'b0;
      chk("stall_after_flush", bus.stallCount, STALL_EN ? 32'd5 : 32'd0);
      chk("stall_flush_outValid", bus.outValid, 0);
      reset = 1'b0;
      tick();
      chk("stall_after_reset2", bus.stallCount, 0);
      reset = 1'b1;
      tick();

      // Streaming 1000 entries with random valid/ready
      n0   = dut_out.size();
      cyc  = 0;
      sent = 0;
      while (sent < 1000 && cyc < 20000) begin
         bit acc;
         bus.inValid  = ($urandom_range(0, 4) != 0);
         bus.inCtrl   = CW'(sent * 7);
         bus.inData   = {DW'(sent * 3 + 2), DW'(sent * 3 + 1), DW'(sent * 3)};
         bus.outReady = ($urandom_range(0, 2) != 0);
         acc          = bus.inValid && bus.inReady;
         tick();
         cyc++;
         if (acc) begin
            exp_q.push_back('{bus.inCtrl, bus.inData});
            sent++;
         end
      end
      bus.inValid  = 1'b0;
      bus.outReady = 1'b1;
      cyc          = 0;
      while (dut_out.size() - n0 < exp_q.size() && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("stream_count", dut_out.size() - n0, 1000);
      for (int k = 0; k < exp_q.size() && n0 + k < dut_out.size(); k++) begin
         chk("stream_data", dut_out[n0+k].data, exp_q[k].data);
         chk("stream_ctrl", dut_out[n0+k].ctrl, exp_q[k].ctrl);
      end
      chk("max_occupancy", max_occ, DEPTH + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
